// File: rtl/popcount_arbiter.sv
// rtl/popcount_arbiter.sv - round-robin front end sharing one popcount datapath among N_REQ requesters
module popcount_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int FUNC_ID_W = 3,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int STATUS_W  = 3,
  parameter logic [STATUS_W-1:0] CFU_OK           = '0,
  parameter logic [STATUS_W-1:0] CFU_ERROR_CUSTOM = '1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*FUNC_ID_W-1:0]  req_func,
  input  logic [N_REQ*DATA_W-1:0]     req_data0,
  input  logic [N_REQ*DATA_W-1:0]     req_data1,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [DATA_W-1:0]           resp_data,
  output logic [STATUS_W-1:0]         resp_status,
  output logic [DATA_W-1:0]           pc_in,
  input  logic [DATA_W-1:0]           pc_count
);

  localparam logic [FUNC_ID_W-1:0] F_POP   = FUNC_ID_W'(0);
  localparam logic [FUNC_ID_W-1:0] F_POP2  = FUNC_ID_W'(1);
  localparam logic [FUNC_ID_W-1:0] F_ACC   = FUNC_ID_W'(2);
  localparam logic [FUNC_ID_W-1:0] F_RDCLR = FUNC_ID_W'(3);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, RESP} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       last_grant, grant, cand, cur_id;
  logic                  grant_found;
  logic [FUNC_ID_W-1:0]  cur_func;
  logic [DATA_W-1:0]     op0, op1, cnt0;
  logic [DATA_W-1:0]     acc [N_REQ];

  // Scan starts one past the last winner so every requester is reached within N_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready = N_REQ'(1) << grant;
  end

  always_comb begin
    pc_in = '0;
    if (state == PASS0)      pc_in = op0;
    else if (state == PASS1) pc_in = op1;
  end

  assign resp_valid = (state == RESP);
  assign resp_id    = cur_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = PASS0;
      PASS0:   state_nxt = (cur_func == F_POP2) ? PASS1 : RESP;
      PASS1:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= ID_W'(N_REQ - 1);
      cur_id      <= '0;
      cur_func    <= '0;
      op0         <= '0;
      op1         <= '0;
      cnt0        <= '0;
      resp_data   <= '0;
      resp_status <= CFU_OK;
      for (int i = 0; i < N_REQ; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_found) begin
          last_grant <= grant;
          cur_id     <= grant;
          cur_func   <= req_func[grant*FUNC_ID_W +: FUNC_ID_W];
          op0        <= req_data0[grant*DATA_W +: DATA_W];
          op1        <= req_data1[grant*DATA_W +: DATA_W];
        end
        PASS0: begin
          cnt0        <= pc_count;
          resp_status <= CFU_OK;
          case (cur_func)
            F_POP:   resp_data <= pc_count;
            F_POP2:  ;
            F_ACC: begin
              acc[cur_id] <= acc[cur_id] + pc_count;
              resp_data   <= acc[cur_id] + pc_count;
            end
            F_RDCLR: begin
              resp_data   <= acc[cur_id];
              acc[cur_id] <= '0;
            end
            default: begin
              resp_data   <= '0;
              resp_status <= CFU_ERROR_CUSTOM;
            end
          endcase
        end
        // Two popcounts of DATA_W bits sum to at most 2*DATA_W, which always fits.
        PASS1: resp_data <= cnt0 + pc_count;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_arbiter.sv
// tb/tb_popcount_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_popcount_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int FW = 3;
  localparam int IW = 2;
  localparam logic [2:0] ST_OK  = 3'd0;
  localparam logic [2:0] ST_ERR = 3'd7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_func;
  logic [N*DW-1:0] req_data0, req_data1;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data;
  logic [2:0]      resp_status;
  logic [DW-1:0]   pc_in, pc_count;

  logic [FW-1:0] f_a [N];
  logic [DW-1:0] d0_a [N];
  logic [DW-1:0] d1_a [N];

  always_comb begin
    req_func = '0; req_data0 = '0; req_data1 = '0;
    for (int r = 0; r < N; r++) begin
      req_func[r*FW +: FW]  = f_a[r];
      req_data0[r*DW +: DW] = d0_a[r];
      req_data1[r*DW +: DW] = d1_a[r];
    end
  end

  assign pc_count = DW'($countones(pc_in));

  popcount_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_status(resp_status), .pc_in(pc_in), .pc_count(pc_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding request, per-requester accumulators.
  logic [DW-1:0] m_acc [N];
  int            m_last, m_start, m_lat, m_id;
  bit            m_busy;
  logic [DW-1:0] m_d0, m_d1, m_res;
  logic [2:0]    m_st;
  int            cyc = 0;

  function automatic int pick();
    for (int i = 1; i <= N; i++) begin
      int r = (m_last + i) % N;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] cnt(input logic [DW-1:0] v);
    return DW'($countones(v));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = N - 1;
    for (int r = 0; r < N; r++) m_acc[r] = '0;
  endtask

  always @(negedge clk) begin
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_pc;
    bit            e_v;
    int            g, k;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_status", resp_status, ST_OK);
      chk("rst_pc_in", pc_in, 0);
      model_reset();
    end else begin
      e_rdy = '0; e_pc = '0; e_v = 0; g = -1;
      if (!m_busy) begin
        g = pick();
        if (g >= 0) e_rdy[g] = 1'b1;
      end else begin
        k = cyc - m_start;
        if (k == 1) e_pc = m_d0;
        else if (k == 2 && m_lat == 3) e_pc = m_d1;
        e_v = (k >= m_lat);
      end
      chk("req_ready", req_ready, e_rdy);
      chk("pc_in", pc_in, e_pc);
      chk("resp_valid", resp_valid, e_v);
      if (e_v) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_data", resp_data, m_res);
        chk("resp_status", resp_status, m_st);
      end
      if (g >= 0) begin
        m_busy = 1; m_start = cyc; m_id = g; m_last = g;
        m_d0 = d0_a[g]; m_d1 = d1_a[g]; m_st = ST_OK;
        m_lat = (f_a[g] == 1) ? 3 : 2;
        case (f_a[g])
          0: m_res = cnt(m_d0);
          1: m_res = cnt(m_d0) + cnt(m_d1);
          2: begin m_acc[g] = m_acc[g] + cnt(m_d0); m_res = m_acc[g]; end
          3: begin m_res = m_acc[g]; m_acc[g] = '0; end
          default: begin m_res = '0; m_st = ST_ERR; end
        endcase
      end else if (e_v && resp_ready) begin
        m_busy = 0;
      end
    end
  end

  int            c_id [8];
  logic [DW-1:0] c_dat [8];
  logic [2:0]    c_st [8];

  // Collects n handshakes; optionally drops each requester's valid once accepted.
  task automatic collect(input int n, input bit drop);
    int got = 0;
    int t = 0;
    logic [N-1:0] rs;
    while (got < n && t < 100) begin
      @(negedge clk); t++;
      rs = req_ready;
      if (resp_valid && resp_ready) begin
        c_id[got] = int'(resp_id); c_dat[got] = resp_data; c_st[got] = resp_status; got++;
      end
      @(posedge clk); #1;
      if (drop) req_valid = req_valid & ~rs;
    end
    if (got < n) begin
      n_cmp++; n_bad++;
      $display("FAIL collect_timeout: got %0d responses expected %0d", got, n);
    end
  endtask

  task automatic issue(input int r, input logic [2:0] f, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1);
    f_a[r] = f; d0_a[r] = d0; d1_a[r] = d1; req_valid[r] = 1'b1;
    collect(1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rs;
    int t;
    for (int r = 0; r < N; r++) begin f_a[r] = '0; d0_a[r] = '0; d1_a[r] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin: all hold POP from reset.
    for (int r = 0; r < N; r++) begin f_a[r] = 3'd0; d0_a[r] = DW'((1 << (r + 1)) - 1); end
    req_valid = '1;
    collect(5, 0);
    req_valid = '0;
    chk("rr_id0", c_id[0], 0); chk("rr_id1", c_id[1], 1);
    chk("rr_id2", c_id[2], 2); chk("rr_id3", c_id[3], 3);
    chk("rr_id4", c_id[4], 0);
    chk("rr_data3", c_dat[3], 4);

    issue(2, 3'd0, 32'hF0F0_0001, 32'h0);
    chk("pop_id", c_id[0], 2); chk("pop_data", c_dat[0], 9); chk("pop_status", c_st[0], ST_OK);
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'h0000_0003);
    chk("pop2_data", c_dat[0], 34);

    issue(1, 3'd2, 32'hFF, 32'h0);      chk("acc1", c_dat[0], 8);
    issue(1, 3'd2, 32'h0F, 32'h0);      chk("acc2", c_dat[0], 12);
    issue(0, 3'd3, 32'h0, 32'h0);       chk("rdclr_req0", c_dat[0], 0);
    issue(1, 3'd3, 32'h0, 32'h0);       chk("rdclr1", c_dat[0], 12);
    issue(1, 3'd3, 32'h0, 32'h0);       chk("rdclr2", c_dat[0], 0);

    // Illegal function under backpressure; a second requester waits meanwhile.
    resp_ready = 1'b0;
    f_a[1] = 3'd5; d0_a[1] = 32'h1234; req_valid[1] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[1] && t < 20);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    f_a[3] = 3'd0; d0_a[3] = 32'hFF; req_valid[3] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!resp_valid && t < 10);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1); chk("bp_data", resp_data, 0);
      chk("bp_status", resp_status, ST_ERR); chk("bp_id", resp_id, 1);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    collect(2, 1);
    chk("bp_hs_id", c_id[0], 1); chk("bp_next_id", c_id[1], 3); chk("bp_next_data", c_dat[1], 8);

    // Reset in PASS1 after accumulator activity.
    issue(2, 3'd2, 32'hFF, 32'h0);      chk("pre_rst_acc", c_dat[0], 8);
    f_a[3] = 3'd1; d0_a[3] = 32'h7; d1_a[3] = 32'hF0; req_valid[3] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; rs = req_ready; end while (!rs[3] && t < 20);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (pc_in !== 32'hF0 && t < 5);
    chk("pass1_seen", pc_in, 32'hF0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 0); chk("async_rst_pc", pc_in, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    f_a[0] = 3'd0; d0_a[0] = 32'h3; f_a[2] = 3'd3;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1;
    collect(2, 1);
    chk("post_rst_first", c_id[0], 0); chk("post_rst_pop", c_dat[0], 2);
    chk("post_rst_rdclr_id", c_id[1], 2); chk("post_rst_rdclr", c_dat[1], 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); rs = req_ready;
      @(posedge clk); #1;
      for (int r = 0; r < N; r++) begin
        if (rs[r]) begin
          req_valid[r] = 1'b0;
          d0_a[r] = $urandom(); d1_a[r] = $urandom(); f_a[r] = 3'($urandom_range(0, 7));
        end else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
          f_a[r]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          d0_a[r] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom();
          d1_a[r] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom();
          req_valid[r] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0; resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
